// File: rtl/inst_fetch_queue.sv
// inst_fetch_queue
// Dual-issue instruction fetch buffer. Fetch offers up to two {pc, inst}
// pairs per cycle; decode sees the oldest two entries show-ahead and
// consumes up to two per cycle. A flush discards everything buffered.
// Storage is a circular array addressed by a head (rd) and a tail (wr)
// pointer, with a registered occupancy count to disambiguate full/empty.

module inst_fetch_queue #(
    parameter int DEPTH = 8,
    parameter int PTR_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic [1:0]       push_cnt,
    input  logic [31:0]      in_pc1,
    input  logic [31:0]      in_inst1,
    input  logic [31:0]      in_pc2,
    input  logic [31:0]      in_inst2,
    output logic             in_ready,
    input  logic [1:0]       pop_cnt,
    output logic             out_valid1,
    output logic [31:0]      out_pc1,
    output logic [31:0]      out_inst1,
    output logic             out_valid2,
    output logic [31:0]      out_pc2,
    output logic [31:0]      out_inst2,
    output logic [PTR_W:0]   count
);

    // Highest occupancy at which two more entries still fit.
    localparam logic [PTR_W:0] READY_MAX = (PTR_W+1)'(DEPTH - 2);

    // Entry storage; no reset needed, validity is tracked by count.
    logic [31:0] pc_mem   [DEPTH];
    logic [31:0] inst_mem [DEPTH];

    logic [PTR_W-1:0] rd_reg, rd_next;
    logic [PTR_W-1:0] wr_reg, wr_next;
    logic [PTR_W:0]   count_reg, count_next;

    logic [PTR_W-1:0] rd_plus1;
    logic [PTR_W-1:0] wr_plus1;

    logic [1:0]       push_req;
    logic [1:0]       pop_req;
    logic [1:0]       push_eff;
    logic [1:0]       pop_eff;

    logic [DEPTH-1:0] wen_lane1;
    logic [DEPTH-1:0] wen_lane2;

    assign rd_plus1 = rd_reg + PTR_W'(1);
    assign wr_plus1 = wr_reg + PTR_W'(1);

    // Readiness depends only on registered occupancy, so a same-cycle pop
    // never creates a combinational path from decode back to fetch.
    assign in_ready = (count_reg <= READY_MAX);

    // Saturate requests at two and clip pushes by readiness, pops by the
    // occupancy at the start of the cycle.
    always_comb begin
        push_req = (push_cnt == 2'd3) ? 2'd2 : push_cnt;
        pop_req  = (pop_cnt  == 2'd3) ? 2'd2 : pop_cnt;
        push_eff = in_ready ? push_req : 2'd0;
        pop_eff  = pop_req;
        if (count_reg == '0) begin
            pop_eff = 2'd0;
        end else if ((count_reg == (PTR_W+1)'(1)) && (pop_req == 2'd2)) begin
            pop_eff = 2'd1;
        end
    end

    // Pointer and occupancy update; flush discards the same-cycle push/pop.
    always_comb begin
        rd_next    = rd_reg;
        wr_next    = wr_reg;
        count_next = count_reg;
        if (flush) begin
            rd_next    = '0;
            wr_next    = '0;
            count_next = '0;
        end else begin
            rd_next    = rd_reg + PTR_W'(pop_eff);
            wr_next    = wr_reg + PTR_W'(push_eff);
            count_next = count_reg + (PTR_W+1)'(push_eff) - (PTR_W+1)'(pop_eff);
        end
    end

    // Per-entry write enables: lane 1 lands at tail, lane 2 at tail+1.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_wen
            assign wen_lane1[gi] = !flush && (push_eff != 2'd0)
                                   && (wr_reg == PTR_W'(gi));
            assign wen_lane2[gi] = !flush && (push_eff == 2'd2)
                                   && (wr_plus1 == PTR_W'(gi));
        end
    endgenerate

    // Write accepted instructions into the circular array.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (wen_lane1[i]) begin
                pc_mem[i]   <= in_pc1;
                inst_mem[i] <= in_inst1;
            end else if (wen_lane2[i]) begin
                pc_mem[i]   <= in_pc2;
                inst_mem[i] <= in_inst2;
            end
        end
    end

    // Queue state registers with immediate reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_reg    <= '0;
            wr_reg    <= '0;
            count_reg <= '0;
        end else begin
            rd_reg    <= rd_next;
            wr_reg    <= wr_next;
            count_reg <= count_next;
        end
    end

    // Show-ahead outputs; an empty lane reads as all zeros.
    always_comb begin
        out_valid1 = (count_reg != '0);
        out_valid2 = (count_reg >= (PTR_W+1)'(2));
        out_pc1    = out_valid1 ? pc_mem[rd_reg]     : 32'd0;
        out_inst1  = out_valid1 ? inst_mem[rd_reg]   : 32'd0;
        out_pc2    = out_valid2 ? pc_mem[rd_plus1]   : 32'd0;
        out_inst2  = out_valid2 ? inst_mem[rd_plus1] : 32'd0;
    end

    assign count = count_reg;

endmodule

// File: doc/inst_fetch_queue.md
Name: inst_fetch_queue

Overview:
- Dual-issue instruction fetch buffer between the instruction ROM (two words per cycle) and the dual-issue decode stage.
- Accepts 0–2 {pc, inst} pairs per cycle from fetch and presents the oldest two entries to decode.
- Decode consumes 0–2 entries per cycle, so fetch and decode stall independently.
- A flush from branch/exception redirect clears all buffered instructions.

Parameters:
- DEPTH, 8, number of entries; power of two, ≥ 4.
- PTR_W, 3, log2(DEPTH); count register is PTR_W+1 bits.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- flush  input  1  discard all entries at next edge.
- push_cnt  input  2  instructions offered this cycle: 0, 1, 2 (3 treated as 2).
- in_pc1  input  32  PC of first (older) offered instruction.
- in_inst1  input  32  first offered instruction word.
- in_pc2  input  32  PC of second offered instruction.
- in_inst2  input  32  second offered instruction word.
- in_ready  output  1  free entries ≥ 2; fetch may push.
- pop_cnt  input  2  entries decode consumes this cycle: 0, 1, 2 (3 treated as 2).
- out_valid1  output  1  head entry present.
- out_pc1  output  32  head PC.
- out_inst1  output  32  head instruction.
- out_valid2  output  1  head+1 entry present.
- out_pc2  output  32  head+1 PC.
- out_inst2  output  32  head+1 instruction.
- count  output  PTR_W+1  current occupancy, 0..DEPTH.

Behaviour:
- Storage: circular array of DEPTH {pc, inst} entries, head pointer (rd), tail pointer (wr), registered count. Pointers wrap modulo DEPTH.
- Reset (async, immediate):
  - head = tail = count = 0.
  - in_ready = 1; out_valid1/2 = 0; out_pc/out_inst = 0.
  - Array contents need not be cleared.
- Outputs are show-ahead and combinational from registered state:
  - out_valid1 = (count ≥ 1); out_valid2 = (count ≥ 2).
  - When a lane's valid is 0, its pc and inst outputs are driven to 0.
  - Zero-latency read: an entry written at edge N is visible on the outputs after edge N.
- in_ready = (DEPTH − count ≥ 2), computed from registered count only. A same-cycle pop does not raise in_ready (no combinational path pop → ready).
- Push:
  - Effective push p = min(push_cnt, 2) when in_ready = 1, else 0.
  - When in_ready = 0, the offered instructions are dropped silently; fetch must hold its PC.
  - p = 1 writes lane 1 at tail.
  - p = 2 writes lane 1 at tail and lane 2 at tail+1 (mod DEPTH).
  - tail += p.
- Pop:
  - Effective pop q = min(pop_cnt, 2, count), using pre-update count. Over-pop is clipped and is not an error.
  - head += q.
- Simultaneous push/pop: count_next = count + p − q. Because pop is clipped against old count, a push into an empty queue cannot be popped in the same cycle.
- Flush: highest priority after reset. At the edge it sets head = tail = count = 0 and ignores same-cycle push and pop.
- Ordering: lane 1 is always older than lane 2; queue order is strict program order.
- Wrap: writes and reads spanning index DEPTH−1 → 0 must be correct.
- Invariant: count never exceeds DEPTH, never underflows, and count == (tail − head) mod DEPTH unless full (count == DEPTH ⇔ head == tail with count ≠ 0).

Test Plan:
- Reset: assert rst mid-cycle with count = 5 → count = 0, out_valid1/2 = 0, in_ready = 1 immediately, without waiting for a clock edge.
- Fill:
  - push_cnt = 2 each cycle with PCs 0x00/0x04, 0x08/0x0C, … and pop_cnt = 0.
  - count goes 2, 4, 6; in_ready drops when count = 7 or 8.
  - At count = 6, one more push of 2 → count = 8, in_ready = 0.
  - A further push is dropped and count stays 8.
- Drain order: from full, pop_cnt = 2 each cycle → out_pc1/out_pc2 = 0x00/0x04, then 0x08/0x0C, …; after 4 cycles count = 0 and valids = 0.
- Wrap + simultaneous:
  - Preload 6 entries.
  - Then push_cnt = 2 and pop_cnt = 1 for 6 cycles; count stays ≤ 8.
  - PCs emerge strictly ascending across the index 7 → 0 boundary.
- Clipping: count = 1 and pop_cnt = 2 → count = 0 next cycle, head advances by 1, out_valid2 was 0 during that cycle.
- Flush priority: count = 4 with push_cnt = 2, pop_cnt = 1 and flush = 1 → count = 0 next cycle. The pushed PCs never appear at the outputs.
